// File: rtl/ht_res_mux.sv
// Round-robin merge of CHANNELS result streams into one stream through a 2-entry skid FIFO.
// Optional per-channel accept counters are enabled with HT_RES_MUX_STATS_EN.
module ht_res_mux #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RESULT_W = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [CHANNELS*RESULT_W-1:0] res_i,
    input  logic [CHANNELS-1:0]          res_valid_i,
    output logic [CHANNELS-1:0]          res_ready_o,
    output logic [RESULT_W-1:0]          res_o,
    output logic [$clog2(CHANNELS)-1:0]  res_chan_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i
`ifdef HT_RES_MUX_STATS_EN
    ,
    output logic [CHANNELS*CNT_W-1:0]    stat_cnt_o
`endif
);

    localparam int unsigned ChanW = $clog2(CHANNELS);
    typedef logic [ChanW-1:0] chan_t;

    chan_t                rr_ptr_q, rr_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 rd_ptr_q, wr_ptr_q;
    logic [RESULT_W-1:0]  data_q [2];
    chan_t                chan_q [2];

    logic [RESULT_W-1:0]  res_arr [CHANNELS];
    logic                 gnt_vld;
    chan_t                gnt_idx;
    logic                 in_fire, out_fire;

    always_comb begin
        for (int k = 0; k < int'(CHANNELS); k++) begin
            res_arr[k] = res_i[k*RESULT_W +: RESULT_W];
        end
    end

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin : arb
        int unsigned cand;
        chan_t       cand_c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        cand_c  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cand   = (32'(rr_ptr_q) + i) % CHANNELS;
            cand_c = chan_t'(cand);
            if (!gnt_vld && res_valid_i[cand_c]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_c;
            end
        end
    end

    // Ready never looks at res_ready_i, so a full FIFO stalls inputs for one cycle.
    always_comb begin
        res_ready_o = '0;
        if (rst_i && gnt_vld && (count_q != 2'd2)) begin
            res_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign in_fire  = |(res_ready_o & res_valid_i);
    assign out_fire = (count_q != 2'd0) && res_ready_i;

    always_comb begin
        count_d  = count_q + {1'b0, in_fire} - {1'b0, out_fire};
        rr_ptr_d = rr_ptr_q;
        if (in_fire) begin
            rr_ptr_d = (gnt_idx == chan_t'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            rr_ptr_q <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                chan_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            if (in_fire) begin
                data_q[wr_ptr_q] <= res_arr[gnt_idx];
                chan_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (out_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign res_valid_o = (count_q != 2'd0);
    assign res_o       = data_q[rd_ptr_q];
    assign res_chan_o  = chan_q[rd_ptr_q];

`ifdef HT_RES_MUX_STATS_EN
    logic [CNT_W-1:0] stat_q [CHANNELS];

    // Saturating, so a stuck-busy channel reads as all ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                stat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (in_fire && (gnt_idx == chan_t'(k)) && (stat_q[k] != '1)) begin
                    stat_q[k] <= stat_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stat_cnt_o = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            stat_cnt_o[k*CNT_W +: CNT_W] = stat_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_ht_res_mux.sv
// Scoreboard bench for ht_res_mux: a negedge monitor models arbitration and the FIFO,
// scenario tasks add targeted checks.
module tb_ht_res_mux;

    localparam int unsigned CH = 4;
    localparam int unsigned RW = 64;
    localparam int unsigned CW = 4;

    typedef logic [RW+1:0] ent_t;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [CH*RW-1:0] res_i = '0;
    logic [CH-1:0]   res_valid_i = '0;
    logic [CH-1:0]   res_ready_o;
    logic [RW-1:0]   res_o;
    logic [1:0]      res_chan_o;
    logic            res_valid_o;
    logic            res_ready_i = 1'b0;
`ifdef HT_RES_MUX_STATS_EN
    logic [CH*CW-1:0] stat_cnt_o;
`endif

    ht_res_mux #(
        .CHANNELS (CH),
        .RESULT_W (RW),
        .CNT_W    (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .res_i       (res_i),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_o       (res_o),
        .res_chan_o  (res_chan_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i)
`ifdef HT_RES_MUX_STATS_EN
        ,
        .stat_cnt_o  (stat_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ent_t        exp_q[$];
    int unsigned m_count = 0;
    int unsigned m_rr = 0;
    int unsigned m_stat[CH];
    int unsigned wait_cnt[CH];
    bit          mon_en = 1'b0;

    // Scoreboard monitor: compares DUT against the model, then advances the model
    // for the transfers that the coming rising edge will perform.
    always @(negedge clk_i) begin : mon
        logic [CH-1:0] exp_rdy;
        bit            g_v;
        int unsigned   g;
        int unsigned   c;
        bit            in_f;
        if (mon_en && rst_i) begin
            exp_rdy = '0;
            g_v = 1'b0;
            g = 0;
            for (int i = 0; i < int'(CH); i++) begin
                c = (m_rr + i) % CH;
                if (!g_v && res_valid_i[c]) begin
                    g_v = 1'b1;
                    g = c;
                end
            end
            if (g_v && m_count < 2) exp_rdy[g] = 1'b1;
            in_f = (exp_rdy != '0);

            n_vec++;
            if (res_ready_o !== exp_rdy) begin
                n_err++;
                $display("FAIL sb_ready t=%0t got %b exp %b", $time, res_ready_o, exp_rdy);
            end
            n_vec++;
            if (res_valid_o !== (m_count != 0)) begin
                n_err++;
                $display("FAIL sb_valid t=%0t got %b exp %b", $time, res_valid_o, m_count != 0);
            end
            if (m_count != 0) begin
                n_vec++;
                if ({res_chan_o, res_o} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL sb_data t=%0t got ch%0d %h exp ch%0d %h", $time,
                             res_chan_o, res_o, exp_q[0][RW+1:RW], exp_q[0][RW-1:0]);
                end
            end

            for (int k = 0; k < int'(CH); k++) begin
                if (res_valid_i[k] && !res_ready_o[k]) begin
                    if ((res_ready_o & res_valid_i) != '0) wait_cnt[k]++;
                end else begin
                    wait_cnt[k] = 0;
                end
                if (wait_cnt[k] >= CH) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL starve ch%0d got %0d grants waited exp < %0d", k,
                             wait_cnt[k], CH);
                    wait_cnt[k] = 0;
                end
            end

            if (m_count != 0 && res_ready_i) begin
                void'(exp_q.pop_front());
                m_count--;
            end
            if (in_f) begin
                exp_q.push_back({2'(g), res_i[g*RW +: RW]});
                m_count++;
                m_rr = (g + 1) % CH;
                if (m_stat[g] < (1 << CW) - 1) m_stat[g]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count = 0;
        m_rr = 0;
        for (int k = 0; k < int'(CH); k++) begin
            m_stat[k] = 0;
            wait_cnt[k] = 0;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_i = 1'b0;
        res_valid_i = '0;
        res_ready_i = 1'b0;
        model_clear();
        repeat (2) tick();
        rst_i = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_i = 1'b0;
        res_valid_i = '1;
        res_ready_i = 1'b1;
        for (int k = 0; k < int'(CH); k++) res_i[k*RW +: RW] = {$urandom, $urandom};
        model_clear();
        repeat (3) tick();
        n_vec++;
        if (res_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_valid got %b exp 0", res_valid_o);
        end
        n_vec++;
        if (res_ready_o !== 4'b0000) begin
            n_err++; $display("FAIL rst_ready got %b exp 0000", res_ready_o);
        end
        n_vec++;
        if (res_o !== '0) begin
            n_err++; $display("FAIL rst_data got %h exp 0", res_o);
        end
        n_vec++;
        if (res_chan_o !== 2'd0) begin
            n_err++; $display("FAIL rst_chan got %0d exp 0", res_chan_o);
        end
`ifdef HT_RES_MUX_STATS_EN
        n_vec++;
        if (stat_cnt_o !== '0) begin
            n_err++; $display("FAIL rst_stat got %h exp 0", stat_cnt_o);
        end
`endif
        res_valid_i = '0;
        rst_i = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_first_xfer();
        logic [RW-1:0] v;
        v = 64'h0123_4567_89AB_CDEF;
        res_ready_i = 1'b1;
        res_i[0 +: RW] = v;
        res_valid_i = 4'b0001;
        tick();
        res_valid_i = '0;
        n_vec++;
        if (res_valid_o !== 1'b1 || res_o !== v || res_chan_o !== 2'd0) begin
            n_err++;
            $display("FAIL first_xfer got v%b ch%0d %h exp v1 ch0 %h", res_valid_o,
                     res_chan_o, res_o, v);
        end
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        res_ready_i = 1'b1;
        res_valid_i = '1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < int'(CH); k++) res_i[k*RW +: RW] = {$urandom, $urandom};
            tick();
            n_vec++;
            if (res_valid_o !== 1'b1 || res_chan_o !== 2'(i % 4)) begin
                n_err++;
                $display("FAIL rr_seq cyc%0d got v%b ch%0d exp v1 ch%0d", i, res_valid_o,
                         res_chan_o, i % 4);
            end
        end
        res_valid_i = '0;
        repeat (2) tick();
    endtask

    task automatic test_full();
        do_reset();
        res_ready_i = 1'b0;
        res_i = '0;
        res_i[2*RW +: RW] = 64'hA5;
        res_valid_i = 4'b0100;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (res_ready_o !== 4'b0000 || res_valid_o !== 1'b1 || res_o !== 64'hA5 ||
                res_chan_o !== 2'd2) begin
                n_err++;
                $display("FAIL full_hold cyc%0d got rdy%b v%b ch%0d %h exp 0000 1 ch2 a5", i,
                         res_ready_o, res_valid_o, res_chan_o, res_o);
            end
            tick();
        end
        res_ready_i = 1'b1;
        #1;
        n_vec++;
        if (res_ready_o !== 4'b0000) begin
            n_err++; $display("FAIL full_rdy_indep got %b exp 0000", res_ready_o);
        end
        tick();
        n_vec++;
        if (res_ready_o !== 4'b0100) begin
            n_err++; $display("FAIL full_resume got %b exp 0100", res_ready_o);
        end
        repeat (4) tick();
        res_valid_i = '0;
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        do_reset();
        res_ready_i = 1'b1;
        res_i[1*RW +: RW] = 64'h11;
        res_i[2*RW +: RW] = 64'h22;
        res_valid_i = 4'b0010;
        tick();
        n_vec++;
        if (res_ready_o !== 4'b0010) begin
            n_err++; $display("FAIL wrap_grant got %b exp 0010", res_ready_o);
        end
        tick();
        res_valid_i = 4'b0110;
        #1;
        n_vec++;
        if (res_ready_o !== 4'b0100) begin
            n_err++; $display("FAIL wrap_ptr got %b exp 0100", res_ready_o);
        end
        res_valid_i = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready_i = 1'b0;
        res_i[0 +: RW] = 64'h1111;
        res_valid_i = 4'b0001;
        repeat (2) tick();
        res_valid_i = '0;
        #2;
        mon_en = 1'b0;
        rst_i = 1'b0;
        #1;
        n_vec++;
        if (res_valid_o !== 1'b0 || res_o !== '0) begin
            n_err++;
            $display("FAIL rst_async got v%b %h exp v0 0", res_valid_o, res_o);
        end
        model_clear();
        tick();
        rst_i = 1'b1;
        mon_en = 1'b1;
        res_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (res_valid_o !== 1'b0) begin
                n_err++; $display("FAIL rst_discard cyc%0d got v%b exp v0", i, res_valid_o);
            end
        end
    endtask

`ifdef HT_RES_MUX_STATS_EN
    task automatic test_stats();
        logic [CW-1:0] got;
        do_reset();
        res_ready_i = 1'b1;
        res_valid_i = 4'b1000;
        repeat (20) tick();
        res_valid_i = '0;
        repeat (2) tick();
        for (int k = 0; k < int'(CH); k++) begin
            got = stat_cnt_o[k*CW +: CW];
            n_vec++;
            if (got !== ((k == 3) ? 4'd15 : 4'd0)) begin
                n_err++;
                $display("FAIL stat_sat ch%0d got %0d exp %0d", k, got, (k == 3) ? 15 : 0);
            end
        end
    endtask
`endif

    task automatic test_random();
        int unsigned n;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < int'(CH); k++) res_i[k*RW +: RW] = {$urandom, $urandom};
            res_valid_i = 4'($urandom);
            res_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        res_valid_i = '0;
        res_ready_i = 1'b1;
        n = 0;
        while (res_valid_o && n < 8) begin
            tick();
            n++;
        end
        tick();
        n_vec++;
        if (res_valid_o !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_drain got v%b pending %0d exp v0 pending 0", res_valid_o,
                     exp_q.size());
        end
`ifdef HT_RES_MUX_STATS_EN
        for (int k = 0; k < int'(CH); k++) begin
            n_vec++;
            if (32'(stat_cnt_o[k*CW +: CW]) !== m_stat[k]) begin
                n_err++;
                $display("FAIL rand_stat ch%0d got %0d exp %0d", k, stat_cnt_o[k*CW +: CW],
                         m_stat[k]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_xfer();
        test_round_robin();
        test_full();
        test_wrap();
        test_reset_mid();
`ifdef HT_RES_MUX_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ht_res_mux.md
HT_RES_MUX -- requirements
Module: ht_res_mux

Interface
REQ-001 Parameter CHANNELS, default 4, number of result input channels (legal 2..8).
REQ-002 Parameter RESULT_W, default 64, width of one packed ht_result_t word in bits.
REQ-003 Parameter CNT_W, default 16, width of each per-channel statistics counter.
REQ-004 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-006 res_i  input  CHANNELS*RESULT_W  input results; channel k occupies bits [k*RESULT_W +: RESULT_W].
REQ-007 res_valid_i  input  CHANNELS  per-channel valid.
REQ-008 res_ready_o  output  CHANNELS  per-channel ready; a transfer on channel k occurs when res_valid_i[k] and res_ready_o[k] are both 1.
REQ-009 res_o  output  RESULT_W  merged result.
REQ-010 res_chan_o  output  $clog2(CHANNELS)  source channel of res_o.
REQ-011 res_valid_o  output  1  merged valid.
REQ-012 res_ready_i  input  1  downstream ready; an output transfer occurs when res_valid_o and res_ready_i are both 1.
REQ-013 stat_cnt_o  output  CHANNELS*CNT_W  per-channel accepted-result counters (present only with HT_RES_MUX_STATS_EN).

Function
REQ-014 Output path is a 2-entry FIFO (skid buffer) holding {result, channel}, with occupancy count in 0..2.
REQ-015 res_ready_o depends only on registered state and res_valid_i, never on res_ready_i.
REQ-016 Each cycle, arbitration grants the first channel with res_valid_i=1, searching from round-robin pointer rr_ptr upward with wrap from CHANNELS-1 to 0.
REQ-017 res_ready_o[g] = 1 only for the granted channel g, and only when count < 2; all other bits are 0.
REQ-018 At most one input transfer per cycle.
REQ-019 After an input transfer on channel g, rr_ptr becomes (g+1) mod CHANNELS; with no input transfer, rr_ptr holds.
REQ-020 Latency: a result accepted in cycle N is visible on res_o/res_valid_o in cycle N+1 when the FIFO was empty or simultaneously drained to that entry.
REQ-021 Count next = count + input transfer - output transfer; simultaneous input and output transfers at count 1 keep count 1, sustaining 1 result/cycle.
REQ-022 res_valid_o = (count != 0); res_o/res_chan_o show the oldest entry; order is strictly FIFO.
REQ-023 Full (count 2): no input accepted; an output transfer in the same cycle frees a slot for the next cycle only.
REQ-024 Empty (count 0) with res_ready_i=1: no output transfer, no underflow.
REQ-025 res_o/res_chan_o are held stable while res_valid_o=1 and res_ready_i=0.
REQ-026 A single requesting channel is granted on every cycle that it is valid and count < 2.

Reset
REQ-027 While rst_i=0: count=0, rr_ptr=0, res_valid_o=0, res_ready_o=0, res_o=0, res_chan_o=0, stat_cnt_o=0.
REQ-028 Reset asserted mid-operation discards all buffered results immediately, with no output transfer completing.
REQ-029 First input transfer possible on the first rising edge after rst_i deasserts.

Configuration
REQ-030 Macro HT_RES_MUX_STATS_EN defined: stat_cnt_o exists; counter k increments by 1 on each input transfer on channel k and saturates at 2^CNT_W-1.
REQ-031 Macro HT_RES_MUX_STATS_EN undefined: stat_cnt_o port and counters are absent; all other behaviour is identical.

Verification
REQ-032 CHANNELS=4; ch0..3 all valid continuously; res_ready_i=1 -> output res_chan_o sequence 0,1,2,3,0,... at 1 result/cycle.
REQ-033 ch2 only valid with result 0xA5; res_ready_i=0 -> 2 entries buffered, res_ready_o=0000, res_o stays 0xA5; then res_ready_i=1 -> both delivered in order, then flow resumes.
REQ-034 ch1 valid, rr_ptr=2 -> ch1 granted by wrap-around; rr_ptr becomes 2.
REQ-035 rst_i pulsed low with count=2 -> res_valid_o=0 asynchronously; no result from before reset appears afterwards.
REQ-036 HT_RES_MUX_STATS_EN with CNT_W=4; 20 transfers on ch3 -> stat_cnt_o ch3 = 15, other channels = 0.
REQ-037 Random valid/ready on all channels for 10000 cycles -> every accepted result output exactly once, per-channel order preserved, no channel starved longer than CHANNELS grants.
